add_int32_seq: RTL and testbench
================================

ADD_INT32_SEQ -- requirements
Module: add_int32_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter: SLICE, default 1, bits processed per cycle; SHALL divide WIDTH exactly; legal values 1, 2, 4, 8, 16, 32.
REQ-003 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand bundle offered.
REQ-007 in_ready  output  1  block can accept an operand bundle.
REQ-008 op_sub  input  1  0 = a+b, 1 = a-b (two's complement), sampled with operands.
REQ-009 a  input  WIDTH  first operand.
REQ-010 b  input  WIDTH  second operand.
REQ-011 out_valid  output  1  result bundle held stable.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  sum/difference modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-015 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-016 busy  output  1  high in COMPUTE state.

Function
REQ-017 FSM states: IDLE, COMPUTE, DONE; encoding free.
REQ-018 IDLE: in_ready=1; on in_valid=1, latch a, b, op_sub, register b as ~b if op_sub, set carry register to op_sub, clear slice counter, go COMPUTE.
REQ-019 in_ready SHALL be 1 only in IDLE; in_valid in other states is ignored, operands not sampled.
REQ-020 COMPUTE: each cycle add SLICE LSBs of operand shift registers plus carry register with a SLICE-bit ripple adder; shift sum slice into result register from MSB side; shift operands right by SLICE; update carry register.
REQ-021 Slice counter counts 0..WIDTH/SLICE-1; on last slice go DONE next cycle.
REQ-022 Latency: in_valid/in_ready handshake in cycle T -> out_valid=1 in cycle T+1+WIDTH/SLICE (T+33 at defaults).
REQ-023 Carry into MSB SHALL be captured during last slice for ovf.
REQ-024 DONE: out_valid=1; result, cout, ovf stable until handshake; on out_ready=1 go IDLE next cycle.
REQ-025 No new operand accepted in the DONE handshake cycle; minimum issue interval WIDTH/SLICE+2 cycles.
REQ-026 out_ready while not in DONE has no effect.
REQ-027 result, cout, ovf SHALL retain last computed values in IDLE until next result overwrites them; only out_valid qualifies them.
REQ-028 Arithmetic is modulo 2^WIDTH; no saturation.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE regardless of state, including mid-COMPUTE and DONE; in-flight operation discarded with no out_valid.
REQ-030 Reset values: in_ready=1 after reset (IDLE), out_valid=0, busy=0, result=0, cout=0, ovf=0, counter=0, carry register=0.
REQ-031 rst has priority over in_valid and out_ready in the same cycle.

Verification
REQ-032 Defaults: a=0x0000_0001, b=0xFFFF_FFFF, op_sub=0 -> after 33 cycles out_valid=1, result=0x0000_0000, cout=1, ovf=0.
REQ-033 a=0x7FFF_FFFF, b=0x0000_0001, op_sub=0 -> result=0x8000_0000, cout=0, ovf=1; op_sub=1 with a=0x8000_0000, b=1 -> result=0x7FFF_FFFF, cout=1, ovf=1.
REQ-034 op_sub=1, a=5, b=7 -> result=0xFFFF_FFFE, cout=0, ovf=0.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-036 Assert rst at cycle 10 of COMPUTE -> next cycle IDLE, out_valid never asserted, next operation correct.
REQ-037 Random regression, SLICE in {1,4,32}, 10k vectors vs. reference a±b, checking result, cout, ovf and latency WIDTH/SLICE+1.

Source files
------------

// File: rtl/add_int32_seq_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master side offers operands and accepts results; the slave side is the adder.
interface add_int32_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, cout, ovf, busy
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, cout, ovf, busy
  );
endinterface

// File: rtl/add_int32_seq.sv
// Sequential add/subtract: SLICE bits per cycle through a small ripple adder,
// with a valid/ready handshake on both the operand and the result side.
module add_int32_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 1
) (
  input  logic          clk,
  input  logic          rst,
  add_int32_seq_if.slave bus
);

  localparam int NUM_SLICES = WIDTH / SLICE;
  localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE-1:0]       sum_slice;
  logic [SLICE:0]         c;
  logic [WIDTH+SLICE-1:0] sr_cat;
  logic [WIDTH-1:0]       sr_shifted;
  logic                   last_slice;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_sr_q <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_sr_q <= sum_sr_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sum_sr_d   = sum_sr_q;
    result_d   = result_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    sum_slice  = '0;
    c          = '0;

    // c[SLICE-1] is the carry into the slice MSB, which on the final slice is the carry into bit WIDTH-1.
    c[0] = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      sum_slice[i] = a_q[i] ^ b_q[i] ^ c[i];
      c[i+1]       = (a_q[i] & b_q[i]) | (c[i] & (a_q[i] ^ b_q[i]));
    end

    sr_cat     = {sum_slice, sum_sr_q};
    sr_shifted = sr_cat[WIDTH+SLICE-1:SLICE];
    last_slice = (cnt_q == CNT_W'(NUM_SLICES - 1));

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.op_sub ? ~bus.b : bus.b;
          carry_d = bus.op_sub;
          cnt_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        sum_sr_d = sr_shifted;
        a_d      = a_q >> SLICE;
        b_d      = b_q >> SLICE;
        carry_d  = c[SLICE];
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_slice) begin
          result_d = sr_shifted;
          cout_d   = c[SLICE];
          ovf_d    = c[SLICE-1] ^ c[SLICE];
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == COMPUTE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_add_int32_seq.sv
// Directed-vector and corner-sequence bench for add_int32_seq at default parameters.
module tb_add_int32_seq;

  localparam int WIDTH      = 32;
  localparam int SLICE      = 1;
  localparam int NUM_SLICES = WIDTH / SLICE;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op_sub;
    logic [31:0] exp_result;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  add_int32_seq_if #(.WIDTH(WIDTH)) bus ();

  add_int32_seq #(
    .WIDTH(WIDTH),
    .SLICE(SLICE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic op);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin
      step();
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_timeout actual=0 expected=1");
    end
    bus.a        = av;
    bus.b        = bv;
    bus.op_sub   = op;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Counts clock edges after the accepting edge until out_valid rises.
  task automatic waitResult(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic releaseResult();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checkOutput("idle_after_ack", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int lat;
    applyStimulus(v.a, v.b, v.op_sub);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
    waitResult(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(NUM_SLICES));
    checkOutput({tag, "_result"}, bus.result, v.exp_result);
    checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(v.exp_cout));
    checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'(v.exp_ovf));
    releaseResult();
  endtask

  vec_t vecs[12];

  initial begin
    vec_t        rv;
    logic [32:0] full;
    logic [31:0] bb;
    int          lat;
    int          seen;

    vecs[0]  = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[6]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[10] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[11] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    rst           = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_result", bus.result, 32'd0);
    checkOutput("rst_cout", 32'(bus.cout), 32'd0);
    checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);

    foreach (vecs[i]) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Held result under backpressure; operand offers during DONE must be ignored.
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
    waitResult(lat);
    checkOutput("bp_latency", 32'(lat), 32'(NUM_SLICES));
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      bus.a        = 32'hFFFF_FFFF;
      bus.b        = 32'hFFFF_FFFF;
      step();
      checkOutput("bp_result", bus.result, 32'h2345_6789);
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checkOutput("bp_ack_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_ack_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    checkOutput("bp_no_accept", 32'(bus.busy), 32'd0);
    checkOutput("bp_result_kept", bus.result, 32'h2345_6789);

    // Reset in the tenth COMPUTE cycle discards the operation.
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0);
    repeat (9) step();
    checkOutput("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_mid_result", bus.result, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid) seen++;
      step();
    end
    checkOutput("rst_mid_no_valid", 32'(seen), 32'd0);
    runVector(vecs[6], "after_rst");

    // Random vectors against an arithmetic reference.
    for (int n = 0; n < 300; n++) begin
      rv.a      = $urandom;
      rv.b      = $urandom;
      rv.op_sub = 1'($urandom_range(1, 0));
      bb        = rv.op_sub ? ~rv.b : rv.b;
      full      = {1'b0, rv.a} + {1'b0, bb} + 33'(rv.op_sub);
      rv.exp_result = full[31:0];
      rv.exp_cout   = full[32];
      rv.exp_ovf    = (rv.a[31] == bb[31]) && (full[31] != rv.a[31]);
      runVector(rv, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
